// File: rtl/load_store_unit.sv
// load_store_unit
//   Multi-cycle RV64 load/store sequencer between the control unit and a
//   doubleword-wide data memory with a fixed read latency of MEM_LAT cycles.
//   Loads read the aligned doubleword and extract/extend the addressed lanes.
//   Partial stores perform a read-modify-write of the aligned doubleword.
//   Misaligned accesses and illegal size codes complete at once with Fault.
// Ports:
//   Clk, Reset         clock, asynchronous active-high reset
//   Start, IsStore     request (sampled in IDLE only) and direction
//   Funct3             size/sign code
//   Address, StoreData byte address and store operand
//   Busy, Done, Fault  status: busy outside IDLE, one-cycle done, fault with done
//   LoadData           extended load result (held between loads)
//   mem_raddress, mem_waddress, mem_Datain, mem_Dataout, mem_Wr
//                      data memory interface (full doubleword writes)
module load_store_unit #(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic        IsStore,
    input  logic [2:0]  Funct3,
    input  logic [63:0] Address,
    input  logic [63:0] StoreData,
    output logic        Busy,
    output logic        Done,
    output logic        Fault,
    output logic [63:0] LoadData,
    output logic [63:0] mem_raddress,
    output logic [63:0] mem_waddress,
    output logic [63:0] mem_Datain,
    input  logic [63:0] mem_Dataout,
    output logic        mem_Wr
);

    typedef enum logic [1:0] {IDLE, RD_WAIT, WRITE, DONE} state_t;

    localparam logic [2:0] LAT = 3'(MEM_LAT);

    state_t      state;
    logic [2:0]  cnt;
    logic        lat_is_store;
    logic [2:0]  lat_funct3;
    logic [63:0] lat_addr;
    logic [63:0] lat_sdata;

    logic [5:0]  shamt;
    logic [63:0] size_mask;
    logic [63:0] merged;
    logic [63:0] shifted;
    logic [63:0] extended;
    logic        fault_now;

    // Lane handling works on the latched request while in RD_WAIT.
    always_comb begin
        shamt = {lat_addr[2:0], 3'b000};
        case (lat_funct3[1:0])
            2'b00:   size_mask = 64'h0000_0000_0000_00FF;
            2'b01:   size_mask = 64'h0000_0000_0000_FFFF;
            2'b10:   size_mask = 64'h0000_0000_FFFF_FFFF;
            default: size_mask = '1;
        endcase
        merged  = (mem_Dataout & ~(size_mask << shamt)) | ((lat_sdata & size_mask) << shamt);
        shifted = mem_Dataout >> shamt;
        case (lat_funct3)
            3'b000:  extended = {{56{shifted[7]}}, shifted[7:0]};
            3'b001:  extended = {{48{shifted[15]}}, shifted[15:0]};
            3'b010:  extended = {{32{shifted[31]}}, shifted[31:0]};
            3'b100:  extended = {56'd0, shifted[7:0]};
            3'b101:  extended = {48'd0, shifted[15:0]};
            3'b110:  extended = {32'd0, shifted[31:0]};
            default: extended = shifted;
        endcase
    end

    // Fault is decided from the live inputs on the Start-sampling edge.
    always_comb begin
        fault_now = 1'b0;
        case (Funct3[1:0])
            2'b01:   fault_now = Address[0];
            2'b10:   fault_now = |Address[1:0];
            2'b11:   fault_now = |Address[2:0];
            default: fault_now = 1'b0;
        endcase
        if (IsStore && Funct3[2])
            fault_now = 1'b1;
        if (!IsStore && Funct3 == 3'b111)
            fault_now = 1'b1;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state        <= IDLE;
            cnt          <= '0;
            lat_is_store <= 1'b0;
            lat_funct3   <= '0;
            lat_addr     <= '0;
            lat_sdata    <= '0;
            Busy         <= 1'b0;
            Done         <= 1'b0;
            Fault        <= 1'b0;
            LoadData     <= '0;
            mem_raddress <= '0;
            mem_waddress <= '0;
            mem_Datain   <= '0;
            mem_Wr       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        lat_is_store <= IsStore;
                        lat_funct3   <= Funct3;
                        lat_addr     <= Address;
                        lat_sdata    <= StoreData;
                        Busy         <= 1'b1;
                        mem_raddress <= {Address[63:3], 3'b000};
                        mem_waddress <= {Address[63:3], 3'b000};
                        if (fault_now) begin
                            state <= DONE;
                            Done  <= 1'b1;
                            Fault <= 1'b1;
                        end else if (IsStore && Funct3[1:0] == 2'b11) begin
                            state      <= WRITE;
                            mem_Wr     <= 1'b1;
                            mem_Datain <= StoreData;
                        end else begin
                            state <= RD_WAIT;
                            cnt   <= LAT;
                        end
                    end
                end
                RD_WAIT: begin
                    if (cnt == 3'd1) begin
                        cnt <= '0;
                        if (lat_is_store) begin
                            state      <= WRITE;
                            mem_Wr     <= 1'b1;
                            mem_Datain <= merged;
                        end else begin
                            state    <= DONE;
                            Done     <= 1'b1;
                            LoadData <= extended;
                        end
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                WRITE: begin
                    mem_Wr <= 1'b0;
                    state  <= DONE;
                    Done   <= 1'b1;
                end
                default: begin
                    state        <= IDLE;
                    Done         <= 1'b0;
                    Fault        <= 1'b0;
                    Busy         <= 1'b0;
                    mem_raddress <= '0;
                    mem_waddress <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with MEM_LAT=1 and a small
// combinational-read doubleword memory covering 0x100..0x13F.
module tb_load_store_unit;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic        IsStore = 1'b0;
    logic [2:0]  Funct3 = '0;
    logic [63:0] Address = '0;
    logic [63:0] StoreData = '0;
    logic        Busy, Done, Fault, mem_Wr;
    logic [63:0] LoadData, mem_raddress, mem_waddress, mem_Datain, mem_Dataout;

    logic [63:0] mem [0:7];
    int checks = 0;
    int failures = 0;

    int          lat, wrs;
    logic [63:0] wa, wd;
    bit          flt;
    int          seen_done, seen_wr;

    load_store_unit #(.MEM_LAT(1)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .IsStore(IsStore),
        .Funct3(Funct3), .Address(Address), .StoreData(StoreData),
        .Busy(Busy), .Done(Done), .Fault(Fault), .LoadData(LoadData),
        .mem_raddress(mem_raddress), .mem_waddress(mem_waddress),
        .mem_Datain(mem_Datain), .mem_Dataout(mem_Dataout), .mem_Wr(mem_Wr)
    );

    always #5 Clk = ~Clk;

    assign mem_Dataout = mem[mem_raddress[5:3]];

    always @(posedge Clk) begin
        if (mem_Wr)
            mem[mem_waddress[5:3]] <= mem_Datain;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request, scramble inputs after the sampling edge, and watch
    // up to 10 cycles for Done, recording latency and write activity.
    task automatic run_op(input logic st, input logic [2:0] f3, input logic [63:0] a,
                          input logic [63:0] sd, input bit poke,
                          output int lat_o, output int wrs_o,
                          output logic [63:0] wa_o, output logic [63:0] wd_o,
                          output bit flt_o);
        lat_o = 0; wrs_o = 0; wa_o = '0; wd_o = '0; flt_o = 1'b0;
        @(negedge Clk);
        Start = 1'b1; IsStore = st; Funct3 = f3; Address = a; StoreData = sd;
        @(negedge Clk);
        Start = 1'b0; IsStore = ~st; Funct3 = 3'b111;
        Address = 64'hDEAD_BEEF_0000_0F0F; StoreData = 64'hCAFE_CAFE_CAFE_CAFE;
        for (int i = 1; i <= 10; i++) begin
            if (mem_Wr) begin
                wrs_o++;
                wa_o = mem_waddress;
                wd_o = mem_Datain;
            end
            if (Done) begin
                lat_o = i;
                flt_o = Fault;
                break;
            end
            if (poke) Start = (i % 2 == 1);
            @(negedge Clk);
        end
        Start = 1'b0;
    endtask

    initial begin
        mem[0] = 64'h8877_6655_4433_2211;
        for (int i = 1; i < 8; i++) mem[i] = '0;

        // Reset state
        #12;
        check("rst_busy", {63'd0, Busy}, 64'd0);
        check("rst_done", {63'd0, Done}, 64'd0);
        check("rst_fault", {63'd0, Fault}, 64'd0);
        check("rst_loaddata", LoadData, 64'd0);
        check("rst_wr", {63'd0, mem_Wr}, 64'd0);
        check("rst_raddr", mem_raddress, 64'd0);
        check("rst_waddr", mem_waddress, 64'd0);
        check("rst_datain", mem_Datain, 64'd0);
        Reset = 1'b0;

        // First Start right after reset release: LB 0x107
        Start = 1'b1; IsStore = 1'b0; Funct3 = 3'b000; Address = 64'h107;
        @(posedge Clk); #1;
        Start = 1'b0;
        check("first_busy", {63'd0, Busy}, 64'd1);
        check("first_raddr", mem_raddress, 64'h100);
        @(negedge Clk);
        @(negedge Clk);
        check("lb_done", {63'd0, Done}, 64'd1);
        check("lb_data", LoadData, 64'hFFFF_FFFF_FFFF_FF88);
        check("lb_fault", {63'd0, Fault}, 64'd0);

        run_op(1'b0, 3'b110, 64'h104, '0, 1'b0, lat, wrs, wa, wd, flt);
        check("lwu_lat", 64'(lat), 64'd2);
        check("lwu_data", LoadData, 64'h0000_0000_8877_6655);

        run_op(1'b0, 3'b010, 64'h104, '0, 1'b0, lat, wrs, wa, wd, flt);
        check("lw_data", LoadData, 64'hFFFF_FFFF_8877_6655);

        run_op(1'b0, 3'b001, 64'h102, '0, 1'b0, lat, wrs, wa, wd, flt);
        check("lh_data", LoadData, 64'h0000_0000_0000_4433);

        run_op(1'b0, 3'b101, 64'h106, '0, 1'b0, lat, wrs, wa, wd, flt);
        check("lhu_data", LoadData, 64'h0000_0000_0000_8877);

        // SH read-modify-write
        run_op(1'b1, 3'b001, 64'h102, 64'hABCD, 1'b0, lat, wrs, wa, wd, flt);
        check("sh_lat", 64'(lat), 64'd3);
        check("sh_wrs", 64'(wrs), 64'd1);
        check("sh_waddr", wa, 64'h100);
        check("sh_datain", wd, 64'h8877_6655_ABCD_2211);
        check("sh_mem", mem[0], 64'h8877_6655_ABCD_2211);

        // SD then readback
        run_op(1'b1, 3'b011, 64'h108, 64'h0123_4567_89AB_CDEF, 1'b0, lat, wrs, wa, wd, flt);
        check("sd_lat", 64'(lat), 64'd2);
        check("sd_wrs", 64'(wrs), 64'd1);
        check("sd_waddr", wa, 64'h108);
        check("sd_datain", wd, 64'h0123_4567_89AB_CDEF);
        run_op(1'b0, 3'b011, 64'h108, '0, 1'b0, lat, wrs, wa, wd, flt);
        check("ld_lat", 64'(lat), 64'd2);
        check("ld_data", LoadData, 64'h0123_4567_89AB_CDEF);

        // Misaligned LW faults in one cycle, LoadData held
        run_op(1'b0, 3'b010, 64'h102, '0, 1'b0, lat, wrs, wa, wd, flt);
        check("mis_lat", 64'(lat), 64'd1);
        check("mis_fault", {63'd0, flt}, 64'd1);
        check("mis_wrs", 64'(wrs), 64'd0);
        check("mis_data", LoadData, 64'h0123_4567_89AB_CDEF);

        // LD with Start pulses while busy: ignored
        run_op(1'b0, 3'b011, 64'h100, '0, 1'b1, lat, wrs, wa, wd, flt);
        check("poke_lat", 64'(lat), 64'd2);
        check("poke_data", LoadData, 64'h8877_6655_ABCD_2211);
        @(negedge Clk);
        check("poke_idle", {63'd0, Busy}, 64'd0);

        // Illegal store size code
        run_op(1'b1, 3'b100, 64'h100, 64'h11, 1'b0, lat, wrs, wa, wd, flt);
        check("ill_fault", {63'd0, flt}, 64'd1);
        check("ill_wrs", 64'(wrs), 64'd0);
        check("ill_mem", mem[0], 64'h8877_6655_ABCD_2211);

        // Valid SB
        run_op(1'b1, 3'b000, 64'h105, 64'h99, 1'b0, lat, wrs, wa, wd, flt);
        check("sb_lat", 64'(lat), 64'd3);
        check("sb_mem", mem[0], 64'h8877_9955_ABCD_2211);

        // Reset during RD_WAIT of an SB
        @(negedge Clk);
        Start = 1'b1; IsStore = 1'b1; Funct3 = 3'b000; Address = 64'h101; StoreData = 64'h55;
        @(negedge Clk);
        Start = 1'b0;
        check("abort_busy_before", {63'd0, Busy}, 64'd1);
        Reset = 1'b1;
        #1;
        check("abort_busy", {63'd0, Busy}, 64'd0);
        check("abort_raddr", mem_raddress, 64'd0);
        @(negedge Clk);
        Reset = 1'b0;
        seen_done = 0; seen_wr = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            if (Done) seen_done++;
            if (mem_Wr) seen_wr++;
        end
        check("abort_no_done", 64'(seen_done), 64'd0);
        check("abort_no_wr", 64'(seen_wr), 64'd0);
        check("abort_mem", mem[0], 64'h8877_9955_ABCD_2211);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001: The block SHALL have parameter MEM_LAT, default 1, meaning clock cycles from memory read address to valid Dataout (legal range 1..4).
REQ-002: Clk  input  1  single clock; all state updates on its rising edge.
REQ-003: Reset  input  1  asynchronous, active-high reset.
REQ-004: Start  input  1  request from control unit; sampled only in IDLE.
REQ-005: IsStore  input  1  1 = store, 0 = load; sampled with Start.
REQ-006: Funct3  input  3  RV64 size/sign code (LB 000, LH 001, LW 010, LD 011, LBU 100, LHU 101, LWU 110; SB 000, SH 001, SW 010, SD 011).
REQ-007: Address  input  64  byte address from ALU output register.
REQ-008: StoreData  input  64  store operand from register B.
REQ-009: Busy  output  1  high in every state except IDLE.
REQ-010: Done  output  1  one-cycle completion pulse.
REQ-011: Fault  output  1  valid with Done; misaligned or illegal Funct3.
REQ-012: LoadData  output  64  extended load result; held until the next successful load.
REQ-013: mem_raddress  output  64  doubleword-aligned read address.
REQ-014: mem_waddress  output  64  doubleword-aligned write address.
REQ-015: mem_Datain  output  64  write data to data memory.
REQ-016: mem_Dataout  input  64  read data from data memory.
REQ-017: mem_Wr  output  1  memory write strobe; writes full doubleword.

Function
REQ-018: On the Start-sampling edge the block SHALL latch IsStore, Funct3, Address, StoreData; later input changes SHALL have no effect until IDLE.
REQ-019: Start in any state other than IDLE SHALL be ignored.
REQ-020: States SHALL be IDLE, RD_WAIT, WRITE, DONE.
REQ-021: Fault condition: Address not aligned to access size (half: bit0; word: bits1:0; double: bits2:0), load Funct3 111, or store Funct3 1xx; IDLE->DONE with Fault=1, no memory read or write, LoadData unchanged.
REQ-022: Load: IDLE->RD_WAIT; stay exactly MEM_LAT cycles (down-counter); on the last RD_WAIT edge capture mem_Dataout, select bytes by offset Address[2:0] little-endian, sign-extend (LB/LH/LW) or zero-extend (LBU/LHU/LWU/LD) into LoadData; ->DONE.
REQ-023: SD: IDLE->WRITE; mem_Wr=1 for exactly one cycle with mem_Datain=StoreData; ->DONE.
REQ-024: SB/SH/SW: IDLE->RD_WAIT (MEM_LAT cycles) -> WRITE; mem_Datain = read doubleword with the addressed byte lanes replaced by StoreData low bytes; other lanes unchanged.
REQ-025: DONE: Done=1 for one cycle, then IDLE; Start sampled in the cycle after DONE.
REQ-026: mem_raddress and mem_waddress SHALL equal latched Address with bits 2:0 cleared whenever Busy; 0 in IDLE.
REQ-027: mem_Wr SHALL be 1 only in WRITE.
REQ-028: Done latency from Start edge: load MEM_LAT+1 cycles; SD 2; partial store MEM_LAT+2; fault 1.

Reset
REQ-029: Reset SHALL immediately force IDLE, Busy=0, Done=0, Fault=0, LoadData=0, mem_Wr=0, addresses=0, mem_Datain=0, counter=0.
REQ-030: Reset asserted mid-operation SHALL abort it with no memory write and no Done pulse after release.
REQ-031: The first Start SHALL be accepted on the first rising edge after Reset deasserts.

Verification (MEM_LAT=1)
REQ-032: Memory at 0x100 = 0x8877665544332211; LB Address 0x107 -> Done 2 cycles after Start, LoadData=0xFFFFFFFFFFFFFF88, Fault=0.
REQ-033: Same memory; LWU Address 0x104 -> LoadData=0x0000000088776655; LW -> 0xFFFFFFFF88776655.
REQ-034: Same memory; SH Address 0x102, StoreData=0xABCD -> one mem_Wr pulse, mem_waddress=0x100, mem_Datain=0x88776655ABCD2211, Done 3 cycles after Start.
REQ-035: SD Address 0x108, StoreData=0x0123456789ABCDEF -> mem_Wr in cycle 1, Done in cycle 2, readback LD 0x108 returns 0x0123456789ABCDEF.
REQ-036: LW Address 0x102 -> Done+Fault 1 cycle after Start, mem_Wr never asserted, LoadData unchanged; then Start pulses during Busy of a following LD are ignored.
REQ-037: Reset asserted during RD_WAIT of an SB -> outputs zero immediately, no mem_Wr, no Done after release, memory unchanged.
